// File: rtl/fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_pkg                                                          |
// | Shared types and default widths for the instruction-fetch stage.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fetch_pkg;

    localparam int PC_WIDTH    = 8;
    localparam int INSTR_WIDTH = 8;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_if                                                           |
// | Instruction-memory, IF/ID handshake and redirect signals of fetch. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fetch_if #(
    parameter int PC_WIDTH    = fetch_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH
);
    logic [PC_WIDTH-1:0]    PC;
    logic [INSTR_WIDTH-1:0] Instruction_Code;
    logic                   id_valid;
    logic                   id_ready;
    logic [INSTR_WIDTH-1:0] id_instr;
    logic [PC_WIDTH-1:0]    id_pc;
    logic                   redirect;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   halted;

    modport master (
        output PC, id_valid, id_instr, id_pc, halted,
        input  Instruction_Code, id_ready, redirect, redirect_pc
    );

    modport slave (
        input  PC, id_valid, id_instr, id_pc, halted,
        output Instruction_Code, id_ready, redirect, redirect_pc
    );
endinterface : fetch_if
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_id_register                                                     |
// | Valid/data pipeline register with flush, load and hold controls.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module if_id_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             flush,
    input  logic             hold,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Flush wins over everything; with neither load nor hold the entry
    // is consumed, so only the valid bit drops and the data is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= d;
        end else if (!hold) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign q     = r_data;
endmodule : if_id_register
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage                                                        |
// | PC/FSM of instruction fetch feeding the IF/ID register to decode.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = fetch_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
    parameter int IMEM_DEPTH  = 6,
    parameter int RESET_PC    = 0
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master bus
);
    localparam logic [PC_WIDTH-1:0] c_reset_pc = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] c_last_pc  = PC_WIDTH'(IMEM_DEPTH - 1);
    localparam logic [PC_WIDTH:0]   c_depth    = (PC_WIDTH + 1)'(IMEM_DEPTH);

    fetch_state_t           r_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic                   r_halted;

    logic                   w_id_valid;
    logic [INSTR_WIDTH-1:0] w_id_instr;
    logic [PC_WIDTH-1:0]    w_id_pc;
    logic                   w_cap;
    logic                   w_hold;
    logic                   w_target_ok;

    assign w_cap       = (r_state == FETCH) && (!w_id_valid || bus.id_ready) && !bus.redirect;
    assign w_hold      = w_id_valid && !bus.id_ready;
    // One extra bit so a depth of 2**PC_WIDTH still compares correctly.
    assign w_target_ok = ({1'b0, bus.redirect_pc} < c_depth);

    if_id_register #(
        .WIDTH (PC_WIDTH + INSTR_WIDTH)
    ) u_if_id (
        .clk   (clk),
        .reset (reset),
        .load  (w_cap),
        .flush (bus.redirect),
        .hold  (w_hold),
        .d     ({r_pc, bus.Instruction_Code}),
        .valid (w_id_valid),
        .q     ({w_id_pc, w_id_instr})
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= START;
            r_pc     <= c_reset_pc;
            r_halted <= 1'b0;
        end else if (bus.redirect) begin
            r_pc <= bus.redirect_pc;
            if (w_target_ok) begin
                r_state  <= FETCH;
                r_halted <= 1'b0;
            end else begin
                r_state  <= HALT;
                r_halted <= 1'b1;
            end
        end else begin
            case (r_state)
                START: r_state <= FETCH;
                FETCH: begin
                    if (w_cap) begin
                        // The last image word parks the PC instead of wrapping.
                        if (r_pc == c_last_pc) begin
                            r_state <= DRAIN;
                        end else begin
                            r_pc <= r_pc + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!w_id_valid) begin
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end
                end
                HALT:    r_halted <= 1'b1;
                default: r_state  <= START;
            endcase
        end
    end

    assign bus.PC       = r_pc;
    assign bus.id_valid = w_id_valid;
    assign bus.id_instr = w_id_instr;
    assign bus.id_pc    = w_id_pc;
    assign bus.halted   = r_halted;
endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage                                                     |
// | Directed and randomized checks of fetch_stage against a model.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fetch_stage;
    localparam int DEPTH = 6;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [7:0] mem [0:DEPTH-1];

    fetch_if #(.PC_WIDTH(8), .INSTR_WIDTH(8)) bus ();

    fetch_stage #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (8),
        .IMEM_DEPTH  (DEPTH),
        .RESET_PC    (0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.Instruction_Code = 8'h00;
        if (int'(bus.PC) < DEPTH) bus.Instruction_Code = mem[int'(bus.PC)];
    end

    // Reference model: program-image view of fetch.
    int  m_pc;
    bit  m_valid;
    int  m_instr;
    int  m_idpc;
    bit  m_halted;
    bit  m_settle;     // one idle cycle still owed after reset
    bit  m_exhausted;  // every image word from the current run has been fetched

    task automatic model_reset();
        m_pc = 0; m_valid = 0; m_instr = 0; m_idpc = 0;
        m_halted = 0; m_settle = 1; m_exhausted = 0;
    endtask

    task automatic model_step(input bit rdy, input bit redir, input int rpc);
        bit taken;
        taken = m_valid && rdy;
        if (redir) begin
            m_valid = 0;
            m_pc    = rpc;
            m_settle = 0;
            if (rpc < DEPTH) begin
                m_exhausted = 0; m_halted = 0;
            end else begin
                m_exhausted = 1; m_halted = 1;
            end
        end else if (m_settle) begin
            m_settle = 0;
            if (taken) m_valid = 0;
        end else if (!m_exhausted) begin
            if (!m_valid || rdy) begin
                m_valid = 1;
                m_instr = int'(mem[m_pc]);
                m_idpc  = m_pc;
                if (m_pc == DEPTH - 1) m_exhausted = 1;
                else m_pc = m_pc + 1;
            end
        end else begin
            if (!m_valid) m_halted = 1;
            else if (taken) m_valid = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_pc"},     32'(bus.PC),       32'(m_pc));
        check({tag, "_valid"},  32'(bus.id_valid), 32'(m_valid));
        check({tag, "_instr"},  32'(bus.id_instr), 32'(m_instr));
        check({tag, "_idpc"},   32'(bus.id_pc),    32'(m_idpc));
        check({tag, "_halted"}, 32'(bus.halted),   32'(m_halted));
    endtask

    task automatic cyc(input string tag, input bit rdy, input bit redir, input int rpc);
        bus.id_ready    = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = 8'(rpc);
        model_step(rdy, redir, rpc);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    // Assert reset between edges, check the immediate clear, then release.
    task automatic do_reset(input string tag);
        bus.id_ready = 1'b1;
        bus.redirect = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all({tag, "_async"});
        @(posedge clk);
        #1;
        compare_all({tag, "_held"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.id_ready    = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
        mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
        model_reset();

        do_reset("por");

        // Free run: one idle settle cycle, then one word per cycle.
        cyc("start", 1, 0, 0);
        check("start_novalid", 32'(bus.id_valid), 32'd0);
        cyc("run0", 1, 0, 0);
        check("first_instr", 32'(bus.id_instr), 32'h11);
        check("first_idpc", 32'(bus.id_pc), 32'd0);
        for (int i = 1; i < DEPTH; i++) cyc("run", 1, 0, 0);
        check("last_instr", 32'(bus.id_instr), 32'h66);
        check("last_idpc", 32'(bus.id_pc), 32'd5);
        cyc("drain", 1, 0, 0);
        check("drain_not_halted", 32'(bus.halted), 32'd0);
        cyc("halt", 1, 0, 0);
        check("halted_2_after", 32'(bus.halted), 32'd1);

        // Redirect out of HALT, refetch up to 0x33, then stall.
        cyc("rd0", 1, 1, 0);
        check("rd0_halted_drop", 32'(bus.halted), 32'd0);
        for (int i = 0; i < 3; i++) cyc("refetch", 1, 0, 0);
        check("hold_instr", 32'(bus.id_instr), 32'h33);
        for (int i = 0; i < 3; i++) begin
            cyc("stall", 0, 0, 0);
            check("stall_pc", 32'(bus.PC), 32'd3);
            check("stall_instr", 32'(bus.id_instr), 32'h33);
        end
        cyc("release", 1, 0, 0);
        check("release_instr", 32'(bus.id_instr), 32'h44);

        // Redirect while 0x44 is offered: it is dropped.
        cyc("rd1", 1, 1, 1);
        check("rd1_bubble", 32'(bus.id_valid), 32'd0);
        check("rd1_pc", 32'(bus.PC), 32'd1);
        cyc("rd1_tgt", 1, 0, 0);
        check("rd1_instr", 32'(bus.id_instr), 32'h22);
        check("rd1_idpc", 32'(bus.id_pc), 32'd1);
        for (int i = 0; i < 8; i++) cyc("tohalt", 1, 0, 0);

        // Out-of-image target halts with no output.
        cyc("rd7", 1, 1, 7);
        check("rd7_halted", 32'(bus.halted), 32'd1);
        check("rd7_novalid", 32'(bus.id_valid), 32'd0);
        cyc("rd7_stay", 1, 0, 0);

        // Mid-stream async reset.
        cyc("rd_pre", 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc("pre_rst", 1, 0, 0);
        do_reset("mid");
        cyc("mid_start", 1, 0, 0);
        cyc("mid_first", 1, 0, 0);
        check("mid_first_instr", 32'(bus.id_instr), 32'h11);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bit rdy;
            bit rd;
            int tgt;
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 15) == 0);
            tgt = int'($urandom_range(0, 9));
            if (i % 131 == 130) begin
                do_reset("rnd");
            end else begin
                cyc("rnd", rdy, rd, tgt);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 4-stage pipeline. It owns the program counter, presents `PC` to the combinational instruction memory, and captures the returned `Instruction_Code` into the IF/ID pipeline register toward decode. It supports downstream back-pressure (valid/ready), redirects from execute (branch/jump), and halting at the end of the program image.

## Interface
Parameters
- `PC_WIDTH`, 8: PC and address width.
- `INSTR_WIDTH`, 8: instruction width.
- `IMEM_DEPTH`, 6: number of valid instruction words; legal PCs are 0..IMEM_DEPTH-1. Must be ≤ 2^PC_WIDTH.
- `RESET_PC`, 0: PC value after reset.

Ports
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `PC`  out  PC_WIDTH  address to instruction memory (registered).
- `Instruction_Code`  in  INSTR_WIDTH  memory read data for `PC`, same cycle.
- `id_valid`  out  1  IF/ID register holds a valid instruction.
- `id_ready`  in  1  decode accepts IF/ID contents this cycle.
- `id_instr`  out  INSTR_WIDTH  captured instruction.
- `id_pc`  out  PC_WIDTH  PC of `id_instr`.
- `redirect`  in  1  one-cycle pulse from execute: flush and jump.
- `redirect_pc`  in  PC_WIDTH  redirect target, sampled when `redirect`=1.
- `halted`  out  1  fetch stopped; program image exhausted.

## Operation
- FSM states: START, FETCH, DRAIN, HALT.
- Reset values (async, immediate): state=START, `PC`=RESET_PC, `id_valid`=0, `id_instr`=0, `id_pc`=0, `halted`=0.
- START: no capture for exactly one cycle after reset deasserts (memory image settles). Next state is FETCH.
- Capture condition `cap` = state==FETCH && (!id_valid || id_ready) && !redirect.
- On `cap`: `id_instr`<=Instruction_Code, `id_pc`<=PC, `id_valid`<=1. If PC==IMEM_DEPTH-1, PC holds and state goes to DRAIN; otherwise PC<=PC+1.
- Stall: when `id_valid` && !`id_ready` && !`redirect`, PC, `id_*` and state hold unchanged.
- Consumption without capture (`id_valid` && `id_ready`, not FETCH): `id_valid`<=0 and the data fields hold.
- DRAIN: no capture. The state goes to HALT in the cycle after `id_valid` is 0, or is cleared by consumption.
- HALT: `halted`=1 (registered, asserted in the HALT state). PC holds and no capture occurs.
- Redirect has the highest priority and is valid in any state:
  - `id_valid`<=0; the current IF/ID contents are discarded even if `id_ready`=1.
  - If redirect_pc < IMEM_DEPTH: PC<=redirect_pc and state<=FETCH. This applies from HALT/DRAIN/START too, and `halted` drops.
  - Otherwise: PC<=redirect_pc and state<=HALT.
- Arithmetic: PC+1 is computed at PC_WIDTH bits. Wrap-around never occurs, because the last legal PC transitions to DRAIN.

## Timing
- Fetch latency: an instruction at address A appears on `id_instr` one cycle after `PC`=A, provided there is no stall.
- Throughput: one instruction per cycle while `id_ready`=1.
- Redirect penalty: `redirect` in cycle n gives `PC`=target in n+1, and the target instruction is valid in n+2. `id_valid` is 0 in n+1.
- Handshake: a transfer occurs on an edge with `id_valid`=1 and `id_ready`=1. `id_*` are stable while `id_valid`=1 and `id_ready`=0.
- Reset mid-operation clears the in-flight instruction immediately, with no drain.

## Structure
- Shared package `fetch_pkg`: state enum (START, FETCH, DRAIN, HALT) and the default width constants PC_WIDTH and INSTR_WIDTH.
- Sub-module `if_id_register`: a valid/data pipeline register with load, flush and hold inputs, reusable for later stage boundaries.
- The PC and FSM live in `fetch_stage`.

## Test plan
- Reset then free-run, `id_ready`=1, memory {0x11,0x22,0x33,0x44,0x55,0x66}: the first valid is in the 2nd cycle after reset deassert (0x11 at `id_pc`=0). The bench then sees one word per cycle through 0x66/`id_pc`=5, and `halted`=1 two cycles after the last capture.
- Stall: `id_ready`=0 for 3 cycles while holding 0x33/`id_pc`=2 → `PC` stays 3, outputs stable. On release, 0x44 follows the next cycle.
- Redirect to 1 while 0x44 is held and `id_ready`=1 → 0x44 is dropped, `id_valid`=0 for one cycle, then 0x22/`id_pc`=1.
- Redirect from HALT to 0 → `halted` drops next cycle and the sequence refetches from 0x11. Redirect to 7 → HALT directly with no valid output.
- Async reset asserted mid-stream (between edges) → `id_valid`, `PC` and `halted` clear immediately, and START repeats after deassert.
